// File: rtl/wb_if.sv
// wb_if: Wishbone classic bus signals between one initiator and one responder.
//   adr_o/dat_o/we_o/stb_o/cyc_o : initiator -> responder
//   dat_i/ack_i                  : responder -> initiator
interface wb_if #(parameter int WIDTH = 32, parameter int ADDR_BITS = 15);
  logic [ADDR_BITS-1:0] adr_o;
  logic [WIDTH-1:0] dat_o;
  logic [WIDTH-1:0] dat_i;
  logic we_o;
  logic stb_o;
  logic cyc_o;
  logic ack_i;
  modport master(output adr_o, dat_o, we_o, stb_o, cyc_o, input dat_i, ack_i);
  modport slave(input adr_o, dat_o, we_o, stb_o, cyc_o, output dat_i, ack_i);
endinterface

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-transfer initiator with ack timeout.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (cmd_ready high only in IDLE)
//   cmd_we/adr/dat       : command fields, latched on acceptance
//   rsp_valid/dat/err    : one-cycle response; err flags a timeout abort
//   wb                   : Wishbone master port
module wb_initiator #(
  parameter int WIDTH = 32,
  parameter int ADDR_BITS = 15,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_BITS-1:0] cmd_adr,
  input  logic [WIDTH-1:0]     cmd_dat,
  output logic                 rsp_valid,
  output logic [WIDTH-1:0]     rsp_dat,
  output logic                 rsp_err,
  wb_if.master                 wb
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic take, done_ack, done_to;
  always_comb begin
    take = state == IDLE && cmd_valid;
    done_ack = state == BUS && wb.ack_i;
    // ack wins over an expiring counter in the same cycle
    done_to = state == BUS && !wb.ack_i && TIMEOUT != 0 && cnt == LAST;
    state_nxt = take ? BUS : (done_ack || done_to) ? IDLE : state;
  end
  assign cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.adr_o <= '0;
      wb.dat_o <= '0;
      wb.we_o <= 1'b0;
      wb.stb_o <= 1'b0;
      wb.cyc_o <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_dat <= '0;
      cnt <= '0;
    end else begin
      rsp_valid <= done_ack || done_to;
      if (take) begin
        wb.adr_o <= cmd_adr;
        wb.dat_o <= cmd_dat;
        wb.we_o <= cmd_we;
        wb.stb_o <= 1'b1;
        wb.cyc_o <= 1'b1;
        cnt <= '0;
      end
      if (done_ack || done_to) begin
        wb.stb_o <= 1'b0;
        wb.cyc_o <= 1'b0;
        rsp_err <= done_to;
      end
      if (done_ack && !wb.we_o) rsp_dat <= wb.dat_i;
      if (done_to) rsp_dat <= '0;
      // saturate so a very long wait with TIMEOUT=0 never wraps
      if (state == BUS && !wb.ack_i && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: directed stimulus plus transaction-level model for wb_initiator.
module tb_wb_initiator;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [14:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0, dat_i_tb = 32'h5555AAAA;
  logic ack_comb = 1'b0, ack_force = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  int n_pass = 0, n_total = 0;
  wb_if #(.WIDTH(32), .ADDR_BITS(15)) wb();
  assign wb.ack_i = (ack_comb && wb.stb_o) || ack_force;
  assign wb.dat_i = dat_i_tb;
  wb_initiator #(.WIDTH(32), .ADDR_BITS(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .wb(wb));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Model: a transfer is "busy" from acceptance until ack or the TO-th strobe cycle.
  logic m_busy = 0, m_we = 0, m_rv = 0, m_err = 0;
  logic [14:0] m_adr = '0;
  logic [31:0] m_dat = '0, m_rdat = '0;
  int m_n = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_we = 0; m_rv = 0; m_err = 0; m_adr = '0; m_dat = '0; m_rdat = '0; m_n = 0;
    end else begin
      m_rv = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_n = 0;
        end
      end else begin
        m_n++;
        if (ack_comb || ack_force) begin
          m_busy = 0; m_rv = 1; m_err = 0;
          if (!m_we) m_rdat = dat_i_tb;
        end else if (m_n == TO) begin
          m_busy = 0; m_rv = 1; m_err = 1; m_rdat = '0;
        end
      end
    end
  end
  always @(negedge clk) begin
    check("cmd_ready", cmd_ready, !m_busy);
    check("stb_o", wb.stb_o, m_busy);
    check("cyc_o", wb.cyc_o, m_busy);
    check("we_o", wb.we_o, m_we);
    check("adr_o", wb.adr_o, m_adr);
    check("dat_o", wb.dat_o, m_dat);
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_err", rsp_err, m_err);
    check("rsp_dat", rsp_dat, m_rdat);
  end
  // ack_at: strobe-cycle index (0-based) in which ack_i is forced; negative = never
  task automatic xfer(input logic we, input logic [14:0] adr, input logic [31:0] d,
                      input int ack_at, input logic [31:0] rd, output int stb_n);
    logic got;
    got = 0;
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = d;
    tick;
    cmd_valid = 0; cmd_dat = 32'hFFFF0000;
    stb_n = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      stb_n += int'(wb.stb_o);
      ack_force = (k == ack_at);
      dat_i_tb = (k == ack_at) ? rd : 32'h5555AAAA;
      tick;
      ack_force = 0; dat_i_tb = 32'h5555AAAA;
      got = rsp_valid;
    end
    if (!got) begin
      n_total++;
      $display("FAIL xfer_budget: no rsp_valid within 50 cycles");
    end
  endtask
  initial begin
    int n;
    logic [5:0] pat;
    int rsp_n, bad_ready;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [5:0] pat;
    int rsp_n, bad_ready;
    tick; tick;
    check("rst_stb", wb.stb_o, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_dat", rsp_dat, 0);
    rst_n = 1;
    // write with combinational ack
    ack_comb = 1; cmd_valid = 1; cmd_we = 1; cmd_adr = 15'h0014; cmd_dat = 32'h0000A5A5;
    tick;
    cmd_valid = 0;
    check("wr_stb", wb.stb_o, 1);
    check("wr_we", wb.we_o, 1);
    check("wr_adr", wb.adr_o, 15'h0014);
    check("wr_dat", wb.dat_o, 32'hA5A5);
    check("wr_ready_bus", cmd_ready, 0);
    tick;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_stb_off", wb.stb_o, 0);
    tick;
    check("wr_rsp_pulse", rsp_valid, 0);
    ack_comb = 0;
    // read, ack after 3 wait states
    xfer(0, 15'h0020, 32'h0, 3, 32'hDEADBEEF, n);
    check("rd_stb_cycles", n, 4);
    check("rd_rsp_dat", rsp_dat, 32'hDEADBEEF);
    check("rd_rsp_err", rsp_err, 0);
    // timeout, ack never comes
    xfer(0, 15'h0030, 32'h0, -1, 32'h0, n);
    check("to_stb_cycles", n, TO);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_dat", rsp_dat, 0);
    check("to_ready", cmd_ready, 1);
    // ack in the expiry cycle wins
    xfer(0, 15'h0040, 32'h0, TO - 1, 32'h00001234, n);
    check("exp_rsp_err", rsp_err, 0);
    check("exp_rsp_dat", rsp_dat, 32'h1234);
    // write keeps previous read data
    xfer(1, 15'h0050, 32'hCAFE, 1, 32'h77777777, n);
    check("wr2_rsp_dat_held", rsp_dat, 32'h1234);
    // back-to-back with combinational ack
    ack_comb = 1; cmd_valid = 1; cmd_we = 1; cmd_adr = 15'h0060;
    tick;
    pat = '0; rsp_n = 0; bad_ready = 0;
    for (int k = 0; k < 6; k++) begin
      pat = {pat[4:0], wb.stb_o};
      rsp_n += int'(rsp_valid);
      bad_ready += int'(cmd_ready == wb.stb_o);
      if (k == 4) cmd_valid = 0;
      tick;
    end
    check("b2b_stb_pattern", pat, 6'b101010);
    check("b2b_rsp_count", rsp_n, 3);
    check("b2b_ready_vs_bus", bad_ready, 0);
    ack_comb = 0;
    // stray ack while idle
    ack_force = 1;
    tick;
    check("stray_rsp", rsp_valid, 0);
    tick;
    check("stray_rsp2", rsp_valid, 0);
    check("stray_ready", cmd_ready, 1);
    ack_force = 0;
    // reset in the middle of a transfer
    cmd_valid = 1; cmd_we = 0; cmd_adr = 15'h0070;
    tick;
    cmd_valid = 0;
    tick;
    check("mid_stb", wb.stb_o, 1);
    #2 rst_n = 0;
    #1;
    check("rst_async_stb", wb.stb_o, 0);
    check("rst_async_cyc", wb.cyc_o, 0);
    check("rst_async_rsp", rsp_valid, 0);
    tick;
    rst_n = 1;
    check("rst_release_ready", cmd_ready, 1);
    xfer(1, 15'h0080, 32'h0BADF00D, 1, 32'h0, n);
    check("post_rst_stb_cycles", n, 2);
    check("post_rst_err", rsp_err, 0);
    tick; tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Wishbone classic single-transfer bus initiator (master). It converts a simple command/response interface from a CPU or testbench into Wishbone cycles toward peripheral subsystems such as the GPIO block. It holds the request until the responder acknowledges, returns captured read data, and aborts with an error flag if the responder does not acknowledge within a programmable timeout.

Parameters:
WIDTH, 32, Wishbone data width
ADDR_BITS, 15, Wishbone address width
TIMEOUT, 255, cycles to wait for ack_i before abort; 0 = wait forever

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  ADDR_BITS  command address
cmd_dat  in  WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_dat  out  WIDTH  read data (valid with rsp_valid on reads)
rsp_err  out  1  1 = transfer timed out (valid with rsp_valid)
adr_o  out  ADDR_BITS  Wishbone address
dat_o  out  WIDTH  Wishbone write data
dat_i  in  WIDTH  Wishbone read data
we_o  out  1  Wishbone write enable
stb_o  out  1  Wishbone strobe
cyc_o  out  1  Wishbone cycle
ack_i  in  1  Wishbone acknowledge (may be combinational, same cycle as stb_o)

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. State IDLE; stb_o, cyc_o, we_o, rsp_valid, rsp_err = 0; adr_o, dat_o, rsp_dat = 0; timeout counter = 0.
- All outputs are registered except cmd_ready, which is combinational: 1 exactly in IDLE.
- IDLE: on cmd_valid at edge N, latch cmd_adr→adr_o, cmd_dat→dat_o, cmd_we→we_o; set stb_o = cyc_o = 1; clear counter; go to BUS. stb_o is high from cycle N+1.
- BUS: stb_o, cyc_o, adr_o, dat_o, we_o are held stable; the counter increments each cycle without ack_i.
  - If ack_i is sampled high: stb_o = cyc_o = 0, rsp_valid = 1, rsp_err = 0, go to IDLE. On a read, rsp_dat <= dat_i. On a write, rsp_dat is unchanged.
  - Timeout: TIMEOUT != 0 and counter == TIMEOUT-1 with ack_i low. Then stb_o = cyc_o = 0, rsp_valid = 1, rsp_err = 1, rsp_dat = 0, go to IDLE.
  - ack_i has priority over timeout in the same cycle.
- Latency: with combinational ack, the command is accepted at edge N, stb_o is high in cycle N+1, and rsp_valid is high in cycle N+2. Each wait state adds one cycle.
- rsp_valid is high for exactly one cycle. rsp_err holds its value until the next response. rsp_dat holds until the next read or timeout.
- Back-to-back: the state is IDLE during the rsp_valid cycle, so a new command can be accepted in that same cycle. Maximum throughput is one transfer per 2 cycles.
- ack_i in IDLE is ignored. dat_i is ignored except on a read ack.
- cmd_* inputs are ignored outside an accepting IDLE cycle.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit. The counter saturates and never wraps.
- rst_n asserted mid-transfer: stb_o and cyc_o drop immediately and asynchronously. No response is issued for the aborted command.
- States are exactly IDLE and BUS. Only single classic cycles are generated; no bursts, no err_i or rty_i.

Test Plan:
- Write, combinational ack: cmd_adr=0x0014, cmd_dat=0x0000A5A5, cmd_we=1 at edge N → stb_o/cyc_o/we_o=1 and adr_o=0x0014, dat_o=0xA5A5 in cycle N+1; rsp_valid=1, rsp_err=0 in N+2; stb_o=0 in N+2.
- Read, ack delayed 3 cycles with dat_i=0xDEADBEEF → stb_o high for 4 cycles with the address held; rsp_valid one cycle later with rsp_dat=0xDEADBEEF, rsp_err=0.
- Timeout, TIMEOUT=4, ack_i never asserted → stb_o high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0; cmd_ready=1 in the same cycle.
- Ack at the expiry cycle, TIMEOUT=4, ack_i high in the 4th stb cycle, dat_i=0x1234 → rsp_err=0, rsp_dat=0x1234.
- Back-to-back: cmd_valid held high for 3 commands with combinational ack → stb_o pattern 1,0,1,0,1; three rsp_valid pulses; cmd_ready=0 only in BUS cycles. A stray ack_i pulse in IDLE produces no rsp_valid.
- Reset mid-transfer: rst_n low while stb_o=1 → stb_o, cyc_o, rsp_valid go to 0 immediately. After release, cmd_ready=1 and the next transaction completes normally.
